// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the output feature-map writer.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_H          = 96;
    localparam int DEF_W          = 96;
    localparam int DEF_F          = 3;

    localparam int DEF_OH = DEF_H - DEF_F + 1;
    localparam int DEF_OW = DEF_W - DEF_F + 1;
    localparam int DEF_N  = DEF_OW / 2;

    localparam int ADDR_W = 14;
    localparam int ROW_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/half_row_serializer.sv
// Holds one captured half-row and steps through its elements one per cycle.
module half_row_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 47,
    parameter int CNT_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] elem_data,
    output logic [CNT_W-1:0]      elem_idx,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] cap_q [N];
    logic [CNT_W-1:0]      cnt_q;

    // Snapshot the whole half-row at the handshake so later in_data changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cap_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N; i++) cap_q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Element pointer: cleared on capture, advanced once per write, wraps after the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

    assign last      = (cnt_q == CNT_W'(N - 1));
    assign elem_idx  = cnt_q;
    assign elem_data = cap_q[cnt_q];

endmodule

// File: rtl/fmap_writer.sv
// Collects an output feature map half-row at a time and writes it element by element.
//
// state   | meaning
// S_IDLE  | waiting for start, no frame in progress
// S_WAIT  | ready for the next half-row from the conv units
// S_WRITE | streaming the captured half-row into memory, one element per cycle
// S_DONE  | single-cycle frame_done pulse, then back to idle
module fmap_writer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int H          = DEF_H,
    parameter int W          = DEF_W,
    parameter int F          = DEF_F
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [((W-F+1)/2)*DATA_WIDTH-1:0]     in_data,
    output logic                                  mem_we,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic [ROW_W-1:0]                      row_idx,
    output logic                                  half
);

    localparam int OH    = H - F + 1;
    localparam int OW    = W - F + 1;
    localparam int N     = OW / 2;
    localparam int CNT_W = $clog2(N);

    state_t                state_q, state_nx;
    logic [ROW_W-1:0]      row_q;
    logic                  half_q;
    logic                  load, advance, last, frame_end;
    logic [CNT_W-1:0]      elem_idx;
    logic [DATA_WIDTH-1:0] elem_data;
    logic [ADDR_W-1:0]     addr_calc;

    half_row_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .CNT_W      (CNT_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .in_data   (in_data),
        .elem_data (elem_data),
        .elem_idx  (elem_idx),
        .last      (last)
    );

    assign frame_end = half_q && (row_q == ROW_W'(OH - 1));
    assign addr_calc = ADDR_W'(row_q) * ADDR_W'(OW)
                     + (half_q ? ADDR_W'(N) : '0)
                     + ADDR_W'(elem_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nx;
    end

    // Row / half position: restart on start, step after each half-row, clear when the frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            half_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q  <= '0;
                        half_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (last && !frame_end) begin
                        half_q <= ~half_q;
                        if (half_q) row_q <= row_q + 1'b1;
                    end
                end
                S_DONE: begin
                    row_q  <= '0;
                    half_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nx   = state_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        frame_done = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_nx = S_WAIT;
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                advance = 1'b1;
                if (last) state_nx = frame_end ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = mem_we ? addr_calc : '0;
    assign mem_wdata = mem_we ? elem_data : '0;
    assign row_idx   = row_q;
    assign half      = half_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Self-checking bench for fmap_writer at default parameters.
module tb_fmap_writer;

    localparam int DW = 8;
    localparam int OH = 94;
    localparam int OW = 94;
    localparam int N  = 47;
    localparam int NW = N * DW;
    localparam int AW = 14;
    localparam int HALF_ROWS = 2 * OH;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          frame_done;
    logic [6:0]    row_idx;
    logic          half;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    int we_count = 0;

    int            got_n;
    int            got_wait;
    logic [AW-1:0] got_addr [N];
    logic [DW-1:0] got_data [N];
    logic          we_after;

    fmap_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .row_idx    (row_idx),
        .half       (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (mem_we) we_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [NW-1:0] ramp_vec();
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k + 1);
        return v;
    endfunction

    // Reference: half-row hr covers output row hr/2, columns (hr%2)*N .. +N-1, row-major.
    function automatic int exp_addr(int hr, int k);
        return (hr / 2) * OW + (hr % 2) * N + k;
    endfunction

    // Offers one half-row and records whatever the DUT writes in the N cycles after the handshake.
    task automatic do_half_row(input logic [NW-1:0] data, input bit hold_valid,
                               input bit scramble, input int start_at);
        got_wait = 0;
        in_valid = 1'b1;
        in_data  = data;
        while (!in_ready && got_wait < 200) begin
            tick();
            got_wait++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL handshake_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        if (!hold_valid) in_valid = 1'b0;
        got_n = 0;
        for (int c = 0; c < N; c++) begin
            if (scramble) in_data = rand_vec();
            start = (c == start_at);
            if (mem_we) begin
                if (got_n < N) begin
                    got_addr[got_n] = mem_addr;
                    got_data[got_n] = mem_wdata;
                end
                got_n++;
            end
            tick();
        end
        start    = 1'b0;
        we_after = mem_we;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = rand_vec();
        tick();
        tick();
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        checks++;
        if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++;
        if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %0d want 0", mem_wdata); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        checks++;
        if (row_idx !== 7'd0) begin errors++; $display("FAIL reset_row_idx: got %0d want 0", row_idx); end
        checks++;
        if (half !== 1'b0) begin errors++; $display("FAIL reset_half: got %0b want 0", half); end
        checks++;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_half_row();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %0b want 1", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %0b want 1", in_ready); end
        checks++;
        do_half_row(ramp_vec(), 1'b0, 1'b0, -1);
        if (got_n !== N) begin errors++; $display("FAIL first_write_count: got %0d want %0d", got_n, N); end
        checks++;
        for (int k = 0; k < N; k++) begin
            if (k < got_n) begin
                if (got_addr[k] !== AW'(k)) begin errors++; $display("FAIL first_addr[%0d]: got %0d want %0d", k, got_addr[k], k); end
                checks++;
                if (got_data[k] !== DW'(k + 1)) begin errors++; $display("FAIL first_data[%0d]: got %0d want %0d", k, got_data[k], k + 1); end
                checks++;
            end
        end
        if (we_after !== 1'b0) begin errors++; $display("FAIL first_we_after: got %0b want 0", we_after); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready_after: got %0b want 1", in_ready); end
        checks++;
        if (half !== 1'b1) begin errors++; $display("FAIL first_half_after: got %0b want 1", half); end
        checks++;
        if (row_idx !== 7'd0) begin errors++; $display("FAIL first_row_after: got %0d want 0", row_idx); end
        checks++;
    endtask

    task automatic test_full_frame();
        logic [NW-1:0] vec;
        int fd0, we0;
        reset_dut();
        fd0 = fd_count;
        we0 = we_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int hr = 0; hr < HALF_ROWS; hr++) begin
            vec = rand_vec();
            if (row_idx !== 7'(hr / 2)) begin errors++; $display("FAIL frame_row_idx hr=%0d: got %0d want %0d", hr, row_idx, hr / 2); end
            checks++;
            if (half !== 1'(hr % 2)) begin errors++; $display("FAIL frame_half hr=%0d: got %0b want %0d", hr, half, hr % 2); end
            checks++;
            do_half_row(vec, 1'b1, 1'b0, -1);
            if (got_wait !== 0) begin errors++; $display("FAIL frame_throughput hr=%0d: waited %0d want 0", hr, got_wait); end
            checks++;
            if (got_n !== N) begin errors++; $display("FAIL frame_write_count hr=%0d: got %0d want %0d", hr, got_n, N); end
            checks++;
            for (int k = 0; k < N; k++) begin
                if (k < got_n) begin
                    if (got_addr[k] !== AW'(exp_addr(hr, k))) begin errors++; $display("FAIL frame_addr hr=%0d k=%0d: got %0d want %0d", hr, k, got_addr[k], exp_addr(hr, k)); end
                    checks++;
                    if (got_data[k] !== vec[k*DW +: DW]) begin errors++; $display("FAIL frame_data hr=%0d k=%0d: got %0d want %0d", hr, k, got_data[k], vec[k*DW +: DW]); end
                    checks++;
                end
            end
            if (hr == 11) begin
                if (got_addr[0] !== AW'(517)) begin errors++; $display("FAIL row5_first_addr: got %0d want 517", got_addr[0]); end
                checks++;
                if (got_addr[N-1] !== AW'(563)) begin errors++; $display("FAIL row5_last_addr: got %0d want 563", got_addr[N-1]); end
                checks++;
            end
        end
        in_valid = 1'b0;
        if (got_addr[N-1] !== AW'(8835)) begin errors++; $display("FAIL frame_last_addr: got %0d want 8835", got_addr[N-1]); end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse: got %0b want 1", frame_done); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_in_done: got %0b want 1", busy); end
        checks++;
        if (we_after !== 1'b0) begin errors++; $display("FAIL frame_we_in_done: got %0b want 0", we_after); end
        checks++;
        tick();
        if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %0b want 0", frame_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_fall: got %0b want 0", busy); end
        checks++;
        if (row_idx !== 7'd0 || half !== 1'b0) begin errors++; $display("FAIL frame_pos_clear: row %0d half %0b want 0 0", row_idx, half); end
        checks++;
        tick();
        tick();
        if (fd_count - fd0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_count - fd0); end
        checks++;
        if (we_count - we0 !== OH * OW) begin errors++; $display("FAIL frame_total_writes: got %0d want %0d", we_count - we0, OH * OW); end
        checks++;
    endtask

    task automatic test_data_stability();
        logic [NW-1:0] vec;
        reset_dut();
        start = 1'b1;
        tick();
        start = 1'b0;
        vec = rand_vec();
        do_half_row(vec, 1'b0, 1'b1, -1);
        if (got_n !== N) begin errors++; $display("FAIL stable_write_count: got %0d want %0d", got_n, N); end
        checks++;
        for (int k = 0; k < N; k++) begin
            if (k < got_n) begin
                if (got_data[k] !== vec[k*DW +: DW]) begin errors++; $display("FAIL stable_data[%0d]: got %0d want %0d", k, got_data[k], vec[k*DW +: DW]); end
                checks++;
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int we0;
        reset_dut();
        we0 = we_count;
        in_valid = 1'b1;
        in_data = rand_vec();
        tick();
        in_valid = 1'b0;
        tick();
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_valid_busy: got %0b want 0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_valid_ready: got %0b want 0", in_ready); end
        checks++;
        if (we_count !== we0) begin errors++; $display("FAIL idle_valid_writes: got %0d want %0d", we_count, we0); end
        checks++;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_half_row(rand_vec(), 1'b0, 1'b0, 10);
        if (got_n !== N) begin errors++; $display("FAIL write_start_count: got %0d want %0d", got_n, N); end
        checks++;
        if (got_addr[N-1] !== AW'(N - 1)) begin errors++; $display("FAIL write_start_last_addr: got %0d want %0d", got_addr[N-1], N - 1); end
        checks++;
        if (half !== 1'b1 || row_idx !== 7'd0) begin errors++; $display("FAIL write_start_pos: row %0d half %0b want 0 1", row_idx, half); end
        checks++;
        do_half_row(rand_vec(), 1'b0, 1'b0, -1);
        if (got_addr[0] !== AW'(N)) begin errors++; $display("FAIL write_start_next_addr: got %0d want %0d", got_addr[0], N); end
        checks++;
    endtask

    task automatic test_mid_reset();
        int fd0, we0;
        reset_dut();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int hr = 0; hr < 6; hr++) do_half_row(rand_vec(), 1'b0, 1'b0, -1);
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_row3: got %0b want 1", in_ready); end
        checks++;
        in_valid = 1'b1;
        in_data = rand_vec();
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 19; c++) tick();
        if (mem_we !== 1'b1 || mem_addr !== AW'(3 * OW + 19)) begin errors++; $display("FAIL abort_write20: we %0b addr %0d want 1 %0d", mem_we, mem_addr, 3 * OW + 19); end
        checks++;
        fd0 = fd_count;
        rst = 1'b1;
        tick();
        if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we: got %0b want 0", mem_we); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
        checks++;
        if (row_idx !== 7'd0 || half !== 1'b0) begin errors++; $display("FAIL abort_pos: row %0d half %0b want 0 0", row_idx, half); end
        checks++;
        rst = 1'b0;
        we0 = we_count;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        if (we_count !== we0 || busy !== 1'b0) begin errors++; $display("FAIL abort_needs_start: writes %0d busy %0b want %0d 0", we_count, busy, we0); end
        checks++;
        if (fd_count !== fd0) begin errors++; $display("FAIL abort_no_frame_done: got %0d want %0d", fd_count, fd0); end
        checks++;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_half_row(ramp_vec(), 1'b0, 1'b0, -1);
        if (got_n !== N) begin errors++; $display("FAIL restart_count: got %0d want %0d", got_n, N); end
        checks++;
        if (got_addr[0] !== '0 || got_data[0] !== DW'(1)) begin errors++; $display("FAIL restart_first: addr %0d data %0d want 0 1", got_addr[0], got_data[0]); end
        checks++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        test_reset();
        test_first_half_row();
        test_full_frame();
        test_data_stability();
        test_ignored_inputs();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmap_writer.md
FMAP_WRITER -- requirements
Module: fmap_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per output-feature-map element.
REQ-002 Parameter H, default 96, input image height.
REQ-003 Parameter W, default 96, input image width.
REQ-004 Parameter F, default 3, filter size; derived OH=H-F+1, OW=W-F+1, N=OW/2 (94, 94, 47 at defaults), ADDR_W=14.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin collecting one output frame; sampled in S_IDLE only.
REQ-008 in_valid  in  1  conv units present one half-row of results.
REQ-009 in_ready  out  1  writer can accept a half-row.
REQ-010 in_data  in  N*DATA_WIDTH  half-row results, [0:] ordering, element 0 in bits [0:DATA_WIDTH-1].
REQ-011 mem_we  out  1  output-map memory write strobe.
REQ-012 mem_addr  out  ADDR_W  word address, row-major, element granularity.
REQ-013 mem_wdata  out  DATA_WIDTH  write data.
REQ-014 busy  out  1  high in every state except S_IDLE.
REQ-015 frame_done  out  1  one-cycle pulse after the last write of a frame.
REQ-016 row_idx  out  7  output row currently being collected (0..OH-1).
REQ-017 half  out  1  0 = columns 0..N-1, 1 = columns N..OW-1.

Function
REQ-018 States SHALL be S_IDLE, S_WAIT, S_WRITE, S_DONE.
REQ-019 S_IDLE: start=1 -> S_WAIT with row_idx=0, half=0; otherwise stay; in_ready=0.
REQ-020 S_WAIT: in_ready=1; in_valid&in_ready -> capture in_data into internal half-row register, clear element counter, -> S_WRITE.
REQ-021 S_WRITE: in_ready=0; mem_we=1 every cycle; mem_wdata = captured element[elem]; mem_addr = row_idx*OW + half*N + elem.
REQ-022 Element counter SHALL run 0..N-1, one write per cycle; first write in the cycle after the handshake (latency 1).
REQ-023 On elem=N-1: if half=1 and row_idx=OH-1 -> S_DONE; else toggle half (row_idx+1 when half goes 1->0) and -> S_WAIT.
REQ-024 S_DONE: frame_done=1 for exactly one cycle, -> S_IDLE; row_idx and half return to 0.
REQ-025 Throughput SHALL be N+1 cycles per half-row; in_data changes after capture SHALL NOT affect writes.
REQ-026 start outside S_IDLE SHALL be ignored; in_valid outside S_WAIT SHALL be ignored.
REQ-027 Address arithmetic SHALL be unsigned in ADDR_W bits; max address OH*OW-1 = 8835; no wrap within a frame.
REQ-028 mem_we SHALL be 0 in S_IDLE, S_WAIT, S_DONE.

Reset
REQ-029 rst=1 at a clock edge SHALL force S_IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, row_idx=0, half=0, element counter=0.
REQ-030 Reset mid-frame SHALL abort without frame_done; writes already issued are not retracted; the next frame requires a new start.

Structure
REQ-031 Shared package cnn_pkg SHALL hold DATA_WIDTH, H, W, F defaults, derived OH/OW/N/ADDR_W, and the state encoding.
REQ-032 One sub-module half_row_serializer (capture register plus element counter, outputs element and last flag) is natural; FSM and address generation stay in fmap_writer.

Verification
REQ-033 Reset then start, one half-row with element k = k+1 -> 47 writes, addr 0..46, data 1..47, mem_we contiguous, then in_ready=1 with half=1.
REQ-034 Full frame, 188 half-rows, in_valid held high -> 8836 writes, last addr 8835, frame_done single pulse exactly one cycle after last write, busy falls next cycle.
REQ-035 Second half-row of row 5 -> first addr 5*94+47 = 517, last 563.
REQ-036 in_data changed every cycle during S_WRITE -> written data equals values captured at handshake.
REQ-037 start pulsed in S_WRITE, in_valid pulsed in S_IDLE -> no state change, no writes.
REQ-038 rst asserted at write 20 of row 3 -> next cycle mem_we=0, busy=0, no frame_done; new start restarts at addr 0.
